// File: rtl/sram_ctrl_top.sv
// Serial-staged SRAM row controller with timed write pulse and precharge/sense read.
// Define SRAM_PARITY_EN to add an even-parity cell column per row and flag read mismatches.
module sram_ctrl_top #(
  parameter int ROWS      = 16,
  parameter int COLS      = 8,
  parameter int SENSE_CYC = 2,
  parameter int WR_CYC    = 1
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    serial_in,
  input  logic                    shift,
  input  logic                    w_req,
  input  logic                    r_req,
  input  logic [$clog2(ROWS)-1:0] addr,
  output logic                    shift_done,
  output logic                    busy,
  output logic                    data_valid,
  output logic [COLS-1:0]         data_out,
  output logic                    parity_err
);

  localparam int AW   = $clog2(ROWS);
`ifdef SRAM_PARITY_EN
  localparam int CW   = COLS + 1;
`else
  localparam int CW   = COLS;
`endif
  localparam int CMAX = (SENSE_CYC > WR_CYC) ? SENSE_CYC : WR_CYC;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BCW  = $clog2(COLS + 1);

  localparam int VDD_MV = 1500;
  localparam int VSS_MV = 0;
  localparam int VTH_MV = 800;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_PRECH = 3'd2;
  localparam logic [2:0] S_SENSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Cell array: bit 1 means the cell holds VDD, bit 0 means VSS; powers up at VSS, never reset.
  logic [CW-1:0]   r_array [ROWS] = '{default: '0};

  logic [2:0]      r_state;
  logic [CNTW-1:0] r_cnt;
  logic [AW-1:0]   r_addr;
  logic [COLS-1:0] r_wdata;
  logic [COLS-1:0] r_stage;
  logic [BCW-1:0]  r_bitCnt;
  logic [CW-1:0]   r_bitline;
  logic [COLS-1:0] r_dataOut;
  logic            r_dataValid;
  logic            r_parErr;

  logic            w_addrOk;
  logic            w_wrLast;
  logic            w_senseLast;
  logic [CW-1:0]   w_row;
  logic [CW-1:0]   w_sensed;
  logic [CW-1:0]   w_writeWord;
  logic            w_parityErr;

  assign w_addrOk    = (32'(r_addr) < ROWS);
  assign w_wrLast    = (r_state == S_WRITE) && (r_cnt == CNTW'(WR_CYC - 1));
  assign w_senseLast = (r_state == S_SENSE) && (r_cnt == CNTW'(SENSE_CYC - 1));
  assign w_row       = w_addrOk ? r_array[r_addr] : '0;

  // Precharged bitlines are pulled down by VSS cells; the sense amp compares against VTH.
  always_comb begin
    w_sensed = '0;
    for (int i = 0; i < CW; i++) begin
      w_sensed[i] = (((r_bitline[i] & w_row[i]) ? VDD_MV : VSS_MV) >= VTH_MV);
    end
  end

`ifdef SRAM_PARITY_EN
  assign w_writeWord = {^r_wdata, r_wdata};
  assign w_parityErr = (^w_sensed[COLS-1:0]) != w_sensed[COLS];
`else
  assign w_writeWord = r_wdata;
  assign w_parityErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wrLast && w_addrOk) begin
      r_array[r_addr] <= w_writeWord;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_stage     <= '0;
      r_bitCnt    <= '0;
      r_bitline   <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
    end else begin
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (shift) begin
            r_stage <= (r_stage << 1) | COLS'(serial_in);
            if (r_bitCnt != BCW'(COLS)) begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
          // A simultaneous read request loses to the write and is dropped.
          if (w_req) begin
            r_addr  <= addr;
            r_wdata <= r_stage;
            r_cnt   <= '0;
            r_state <= S_WRITE;
          end else if (r_req) begin
            r_addr  <= addr;
            r_state <= S_PRECH;
          end
        end
        S_WRITE: begin
          if (w_wrLast) begin
            r_bitCnt <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRECH: begin
          r_bitline <= '1;
          r_cnt     <= '0;
          r_state   <= S_SENSE;
        end
        S_SENSE: begin
          r_bitline <= r_bitline & w_row;
          if (w_senseLast) begin
            r_dataOut   <= w_sensed[COLS-1:0];
            r_parErr    <= w_parityErr;
            r_dataValid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign shift_done = (r_bitCnt == BCW'(COLS));
  assign busy       = (r_state != S_IDLE);
  assign data_valid = r_dataValid;
  assign data_out   = r_dataOut;
  assign parity_err = r_parErr;

endmodule

// File: tb/tb_sram_ctrl_top.sv
// Scoreboard bench for sram_ctrl_top: a 16-row default instance and a 12-row instance.
// Expected read words are queued at request time and popped by a monitor on each data_valid.
module tb_sram_ctrl_top;

  localparam int SENSE_CYC = 2;
  localparam int WR_CYC    = 1;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       serialIn;
  logic [3:0] addrIn;
  logic       shiftA, wReqA, rReqA;
  logic       shiftB, wReqB, rReqB;
  logic       shiftDoneA, busyA, dataValidA, parityErrA;
  logic       shiftDoneB, busyB, dataValidB, parityErrB;
  logic [7:0] dataOutA, dataOutB;

  int vectors    = 0;
  int miscompares = 0;
  int pulseA     = 0;
  int pulseB     = 0;
  logic [8:0] expA[$];
  logic [8:0] expB[$];

  always #5 clk = ~clk;

  sram_ctrl_top #(.ROWS(16), .COLS(8), .SENSE_CYC(SENSE_CYC), .WR_CYC(WR_CYC)) dut (
    .clk(clk), .arst_n(arst_n), .serial_in(serialIn), .shift(shiftA),
    .w_req(wReqA), .r_req(rReqA), .addr(addrIn),
    .shift_done(shiftDoneA), .busy(busyA), .data_valid(dataValidA),
    .data_out(dataOutA), .parity_err(parityErrA)
  );

  sram_ctrl_top #(.ROWS(12), .COLS(8), .SENSE_CYC(SENSE_CYC), .WR_CYC(WR_CYC)) dut12 (
    .clk(clk), .arst_n(arst_n), .serial_in(serialIn), .shift(shiftB),
    .w_req(wReqB), .r_req(rReqB), .addr(addrIn),
    .shift_done(shiftDoneB), .busy(busyB), .data_valid(dataValidB),
    .data_out(dataOutB), .parity_err(parityErrB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [8:0] e;
    if (dataValidA) begin
      pulseA++;
      if (expA.size() == 0) begin
        checkOutput("unexpected_valid_A", 1, 0);
      end else begin
        e = expA.pop_front();
        checkOutput("rd_data_A", dataOutA, e[7:0]);
        checkOutput("rd_parity_A", parityErrA, e[8]);
      end
    end
    if (dataValidB) begin
      pulseB++;
      if (expB.size() == 0) begin
        checkOutput("unexpected_valid_B", 1, 0);
      end else begin
        e = expB.pop_front();
        checkOutput("rd_data_B", dataOutB, e[7:0]);
        checkOutput("rd_parity_B", parityErrB, e[8]);
      end
    end
  end

  // Shift the low n bits of word in, most significant first.
  task automatic applyStimulus(input bit sel, input logic [7:0] word, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      serialIn = word[i];
      if (sel) shiftB = 1'b1; else shiftA = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    shiftA = 1'b0;
    shiftB = 1'b0;
  endtask

  task automatic writeRow(input bit sel, input logic [3:0] a, input bit alsoRead);
    @(negedge clk);
    addrIn = a;
    if (sel) begin wReqB = 1'b1; rReqB = alsoRead; end
    else     begin wReqA = 1'b1; rReqA = alsoRead; end
    @(posedge clk); #1;
    checkOutput("busy_in_write", sel ? busyB : busyA, 1);
    @(negedge clk);
    wReqA = 1'b0; rReqA = 1'b0; wReqB = 1'b0; rReqB = 1'b0;
    repeat (WR_CYC) @(posedge clk);
    #1;
    checkOutput("busy_after_write", sel ? busyB : busyA, 0);
    checkOutput("shift_done_cleared", sel ? shiftDoneB : shiftDoneA, 0);
  endtask

  // data_valid must appear in the (SENSE_CYC+2)-th cycle after the sampling edge, not earlier.
  task automatic readRow(input bit sel, input logic [3:0] a, input logic [7:0] d, input bit par);
    if (sel) expB.push_back({par, d}); else expA.push_back({par, d});
    @(negedge clk);
    addrIn = a;
    if (sel) rReqB = 1'b1; else rReqA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rReqA = 1'b0;
    rReqB = 1'b0;
    repeat (SENSE_CYC) @(posedge clk);
    #1;
    checkOutput("valid_not_early", sel ? dataValidB : dataValidA, 0);
    @(posedge clk); #1;
    checkOutput("valid_on_time", sel ? dataValidB : dataValidA, 1);
    @(posedge clk); #1;
    checkOutput("idle_after_read", sel ? busyB : busyA, 0);
  endtask

  initial begin
    int p0;
    serialIn = 1'b0; addrIn = '0;
    shiftA = 1'b0; wReqA = 1'b0; rReqA = 1'b0;
    shiftB = 1'b0; wReqB = 1'b0; rReqB = 1'b0;
    arst_n = 1'b1;
    #3 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_valid", dataValidA, 0);
    checkOutput("rst_data_out", dataOutA, 0);
    checkOutput("rst_shift_done", shiftDoneA, 0);
    checkOutput("rst_parity_err", parityErrA, 0);
    arst_n = 1'b1;

    // Staged word 1,0,1,1,0,0,1,0 = 8'hB2; shift_done only after the eighth bit.
    applyStimulus(0, 8'h59, 7);
    checkOutput("shift_done_7bits", shiftDoneA, 0);
    applyStimulus(0, 8'h00, 1);
    checkOutput("shift_done_8bits", shiftDoneA, 1);
    writeRow(0, 4'd3, 0);
    readRow(0, 4'd3, 8'hB2, 0);

    // Write and read together: write wins, read dropped.
    applyStimulus(0, 8'h5A, 8);
    p0 = pulseA;
    writeRow(0, 4'd5, 1);
    repeat (SENSE_CYC + 3) @(posedge clk);
    #1;
    checkOutput("no_valid_on_conflict", pulseA - p0, 0);
    readRow(0, 4'd5, 8'h5A, 0);
    readRow(0, 4'd3, 8'hB2, 0);

    // Writes leave data_out alone; staging still holds 8'h5A.
    writeRow(0, 4'd9, 0);
    checkOutput("data_out_hold", dataOutA, 8'hB2);
    readRow(0, 4'd10, 8'h00, 0);
    checkOutput("unwritten_row_zero", dataOutA, 8'h00);

    // Read request during SENSE is ignored.
    p0 = pulseA;
    expA.push_back({1'b0, 8'hB2});
    @(negedge clk); addrIn = 4'd3; rReqA = 1'b1;
    @(posedge clk);
    @(negedge clk); rReqA = 1'b0;
    @(posedge clk);
    @(negedge clk); addrIn = 4'd5; rReqA = 1'b1;
    @(posedge clk);
    @(negedge clk); rReqA = 1'b0;
    repeat (SENSE_CYC + 6) @(posedge clk);
    #1;
    checkOutput("one_pulse_when_busy", pulseA - p0, 1);
    checkOutput("busy_read_data", dataOutA, 8'hB2);

    // Reset in SENSE aborts the read; array survives.
    p0 = pulseA;
    @(negedge clk); addrIn = 4'd5; rReqA = 1'b1;
    @(posedge clk);
    @(negedge clk); rReqA = 1'b0;
    @(posedge clk);
    @(negedge clk); arst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busyA, 0);
    checkOutput("abort_data_out", dataOutA, 0);
    checkOutput("abort_valid", dataValidA, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (SENSE_CYC + 3) @(posedge clk);
    #1;
    checkOutput("no_valid_after_abort", pulseA - p0, 0);
    readRow(0, 4'd5, 8'h5A, 0);
    readRow(0, 4'd9, 8'h5A, 0);

    // Partial word: staging was cleared by reset, three bits 1,1,0 give 8'h06.
    applyStimulus(0, 8'h06, 3);
    checkOutput("shift_done_partial", shiftDoneA, 0);
    writeRow(0, 4'd7, 0);
    readRow(0, 4'd7, 8'h06, 0);

    // Twelve-row instance: out-of-range address reads zero and never writes.
    applyStimulus(1, 8'hC3, 8);
    checkOutput("shift_done_B", shiftDoneB, 1);
    writeRow(1, 4'd4, 0);
    readRow(1, 4'd4, 8'hC3, 0);
    readRow(1, 4'd13, 8'h00, 0);
    applyStimulus(1, 8'h3C, 8);
    writeRow(1, 4'd13, 0);
    for (int r = 0; r < 12; r++) begin
      readRow(1, 4'(r), (r == 4) ? 8'hC3 : 8'h00, 0);
    end
    readRow(1, 4'd13, 8'h00, 0);

`ifdef SRAM_PARITY_EN
    applyStimulus(0, 8'hFF, 8);
    writeRow(0, 4'd2, 0);
    @(negedge clk);
    dut.r_array[2][0] = 1'b0;
    readRow(0, 4'd2, 8'hFE, 1);
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained_A", expA.size(), 0);
    checkOutput("scoreboard_drained_B", expB.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_ctrl_top.md
SRAM_CTRL_TOP -- requirements
Module: sram_ctrl_top

Interface
REQ-001 Parameter ROWS, default 16, number of word rows (≥2).
REQ-002 Parameter COLS, default 8, word width in bits (≥1).
REQ-003 Parameter SENSE_CYC, default 2, sense-phase length in cycles (≥1).
REQ-004 Parameter WR_CYC, default 1, write-pulse length in cycles (≥1).
REQ-005 Port clk  input  1  single system clock; all state on rising edge.
REQ-006 Port arst_n  input  1  asynchronous, active-low reset.
REQ-007 Port serial_in  input  1  serial write-data bit.
REQ-008 Port shift  input  1  shift serial_in into staging register this cycle.
REQ-009 Port w_req  input  1  write request; stages staged word into row addr.
REQ-010 Port r_req  input  1  read request for row addr.
REQ-011 Port addr  input  $clog2(ROWS)  row address, sampled with w_req/r_req.
REQ-012 Port shift_done  output  1  high when COLS bits staged since last write.
REQ-013 Port busy  output  1  high while FSM is not IDLE.
REQ-014 Port data_valid  output  1  one-cycle pulse, data_out updated.
REQ-015 Port data_out  output  COLS  last read word.
REQ-016 Port parity_err  output  1  read parity mismatch, qualified by data_valid.

Function
REQ-017 FSM states IDLE, WRITE, PRECH, SENSE, DONE; only IDLE accepts shift, w_req, r_req; all three ignored when busy.
REQ-018 shift in IDLE: staging reg shifts left, serial_in enters bit 0; bit counter increments, saturating at COLS; shift_done = (count == COLS).
REQ-019 w_req in IDLE: latch addr and staging word; IDLE->WRITE; WRITE lasts WR_CYC cycles; on final WRITE cycle latched row cells driven to VDD (bit 1) / VSS (bit 0); then ->IDLE, bit counter cleared.
REQ-020 r_req in IDLE: latch addr; IDLE->PRECH (1 cycle, bitlines at VDD) ->SENSE (SENSE_CYC cycles) ->DONE (1 cycle) ->IDLE.
REQ-021 In DONE: data_out[i] = 1 iff cell voltage ≥ VTH (VDD 1.5, VSS 0.0, VTH 0.8), data_valid = 1.
REQ-022 Read latency: data_valid high exactly SENSE_CYC+2 cycles after the edge sampling r_req.
REQ-023 w_req and r_req both high in IDLE: write wins; read dropped, not queued.
REQ-024 addr ≥ ROWS (non-power-of-two ROWS): write discarded without array change; read completes normally with data_out all zeros, data_valid pulsed.
REQ-025 data_out holds value between reads; writes never alter data_out.
REQ-026 w_req with shift_done low writes current staging contents unchanged (partial word permitted).
REQ-027 Array cells power up at VSS.

Reset
REQ-028 arst_n low asynchronously: FSM->IDLE, busy=0, data_valid=0, data_out=0, parity_err=0, staging reg=0, bit counter=0, shift_done=0.
REQ-029 Array contents unaffected by arst_n; reset during WRITE before final cycle leaves the target row unchanged.
REQ-030 Reset during PRECH/SENSE aborts read; no data_valid pulse produced.

Configuration
REQ-031 Macro SRAM_PARITY_EN defined: one extra cell column per row stores even parity of written word; in DONE parity recomputed from sensed data, parity_err = mismatch, asserted only with data_valid.
REQ-032 Macro SRAM_PARITY_EN undefined: no extra column, parity_err tied 0.

Verification
REQ-033 COLS=8: shift 8 bits 1,0,1,1,0,0,1,0 -> shift_done=1, staging=8'hB2; w_req addr=3 -> busy for WR_CYC cycles; r_req addr=3 -> data_out=8'hB2, data_valid at cycle SENSE_CYC+2.
REQ-034 w_req and r_req same cycle, addr=5 -> write to row 5 only, no data_valid pulse.
REQ-035 r_req while busy in SENSE -> ignored; exactly one data_valid pulse.
REQ-036 arst_n low during SENSE -> outputs zero, no data_valid; later read of same row returns previously written word.
REQ-037 ROWS=12, r_req addr=13 -> data_out=0, data_valid pulsed; w_req addr=13 -> rows 0-11 unchanged.
REQ-038 SRAM_PARITY_EN: force one data cell of row 2 to VSS after writing 8'hFF -> read returns 8'hFE with parity_err=1.
